// File: rtl/dac_ramp_ctrl.sv
// Rate-limited DAC code sequencer feeding the SPI transmitter; DAC_RAMP_SLEW_EN selects stepped slew, else direct jump.
// Latency: target_we to newTxData is 2 clocks when idle; one write per transfer plus UPD_DIV+1 hold clocks.
// Backpressure: writes only while txBusy is low; waits for txBusy rise/fall, times out after BUSY_TMO clocks.
module dac_ramp_ctrl #(
    parameter int STEP     = 16,
    parameter int UPD_DIV  = 100,
    parameter int BUSY_TMO = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [11:0] target,
    input  logic        target_we,
    input  logic        iGain,
    input  logic        txBusy,
    output logic [11:0] odata,
    output logic        oGain,
    output logic        newTxData,
    output logic        at_target,
    output logic        err_tmo
);
    localparam int CNT_MAX = (UPD_DIV > BUSY_TMO) ? UPD_DIV : BUSY_TMO;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] HOLD_END = CW'(UPD_DIV);
    localparam logic [CW-1:0] TMO_LAST = CW'(BUSY_TMO - 1);

    if (STEP < 1 || STEP > 4095 || BUSY_TMO < 3) begin : g_bad_param
        $error("dac_ramp_ctrl: STEP must be 1..4095 and BUSY_TMO >= 3");
    end

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, HOLD} state_t;

    state_t        state, state_nxt;
    logic [11:0]   tgt, cur, cur_bak, nxt_code;
    logic          gain_l, gain_cur, gain_bak, pend;
    logic [CW-1:0] cnt;
    logic          go_issue, cnt_clr, cnt_inc, tmo_hit;

`ifdef DAC_RAMP_SLEW_EN
    localparam logic [12:0] STEP13 = 13'(STEP);
    logic [12:0] diff_up, diff_dn;
    logic [11:0] step_up, step_dn;

    always_comb begin
        diff_up = {1'b0, tgt} - {1'b0, cur};
        diff_dn = {1'b0, cur} - {1'b0, tgt};
        step_up = (diff_up > STEP13) ? STEP13[11:0] : diff_up[11:0];
        step_dn = (diff_dn > STEP13) ? STEP13[11:0] : diff_dn[11:0];
        if (tgt > cur)
            nxt_code = cur + step_up;
        else if (tgt < cur)
            nxt_code = cur - step_dn;
        else
            nxt_code = cur;
    end
`else
    assign nxt_code = tgt;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // cnt starts at 0 in the ISSUE cycle, so a timeout lands BUSY_TMO clocks after the strobe
    always_comb begin
        state_nxt = state;
        go_issue  = 1'b0;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        tmo_hit   = 1'b0;
        case (state)
            IDLE: begin
                if ((tgt != cur || pend) && !txBusy) begin
                    state_nxt = ISSUE;
                    go_issue  = 1'b1;
                    cnt_clr   = 1'b1;
                end
            end
            ISSUE: begin
                state_nxt = WAIT_BUSY;
                cnt_inc   = 1'b1;
            end
            WAIT_BUSY: begin
                if (txBusy) begin
                    state_nxt = WAIT_DONE;
                end else if (cnt == TMO_LAST) begin
                    state_nxt = HOLD;
                    tmo_hit   = 1'b1;
                    cnt_clr   = 1'b1;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            WAIT_DONE: begin
                if (!txBusy) begin
                    state_nxt = HOLD;
                    cnt_clr   = 1'b1;
                end
            end
            HOLD: begin
                if (cnt == HOLD_END)
                    state_nxt = IDLE;
                else
                    cnt_inc = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tgt       <= '0;
            gain_l    <= 1'b0;
            cur       <= '0;
            gain_cur  <= 1'b0;
            cur_bak   <= '0;
            gain_bak  <= 1'b0;
            pend      <= 1'b1;
            cnt       <= '0;
            odata     <= '0;
            oGain     <= 1'b0;
            newTxData <= 1'b0;
            at_target <= 1'b0;
            err_tmo   <= 1'b0;
        end else begin
            newTxData <= go_issue;
            if (cnt_clr)
                cnt <= '0;
            else if (cnt_inc)
                cnt <= cnt + CW'(1);

            // a write the transmitter never accepted is rolled back so the same step is retried
            if (go_issue) begin
                odata    <= nxt_code;
                oGain    <= gain_l;
                cur_bak  <= cur;
                gain_bak <= gain_cur;
                cur      <= nxt_code;
                gain_cur <= gain_l;
            end else if (tmo_hit) begin
                cur      <= cur_bak;
                gain_cur <= gain_bak;
            end
            if (tmo_hit)
                err_tmo <= 1'b1;

            if (target_we) begin
                tgt    <= target;
                gain_l <= iGain;
                if (go_issue)
                    pend <= (iGain != gain_l);
                else
                    pend <= pend | (iGain != gain_cur) | tmo_hit;
            end else if (go_issue) begin
                pend <= 1'b0;
            end else if (tmo_hit) begin
                pend <= 1'b1;
            end

            at_target <= (state == IDLE) && (tgt == cur) && !pend && !target_we;
        end
    end
endmodule

// File: tb/tb_dac_ramp_ctrl.sv
// Bench for dac_ramp_ctrl: vector table of target changes plus reversal, busy-timeout and async-reset sequences.
module tb_dac_ramp_ctrl;
    localparam int STEP     = 16;
    localparam int UPD_DIV  = 4;
    localparam int BUSY_TMO = 8;
    localparam int TX_LEN   = 12;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [11:0] target;
    logic        target_we;
    logic        iGain;
    logic        txBusy = 1'b0;
    logic [11:0] odata;
    logic        oGain;
    logic        newTxData;
    logic        at_target;
    logic        err_tmo;

    dac_ramp_ctrl #(.STEP(STEP), .UPD_DIV(UPD_DIV), .BUSY_TMO(BUSY_TMO)) dut (
        .clk(clk), .reset(reset), .target(target), .target_we(target_we), .iGain(iGain),
        .txBusy(txBusy), .odata(odata), .oGain(oGain), .newTxData(newTxData),
        .at_target(at_target), .err_tmo(err_tmo)
    );

    always #5 clk = ~clk;

    typedef struct { int code; int gain; int cyc; } wr_t;
    typedef struct { int tgt; int g; int n; int codes[8]; } vec_t;

    wr_t  wr_q[$];
    vec_t vecs[5];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   fall_cyc = -1;
    int   ph = 0;
    int   rem = 0;
    logic tx_dead = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // write monitor followed by the transmitter model: busy 2 clocks after the strobe, for TX_LEN clocks
    always @(posedge clk) begin
        #1;
        if (newTxData === 1'b1) begin
            wr_q.push_back('{int'(odata), int'(oGain), cyc});
            chk("busy_low_at_write", 32'(txBusy), 32'd0);
            if (fall_cyc >= 0)
                chk("hold_gap", 32'(cyc - fall_cyc >= UPD_DIV + 1), 32'd1);
        end
        if (reset) begin
            txBusy   = 1'b0;
            ph       = 0;
            rem      = 0;
            fall_cyc = -1;
        end else if (newTxData === 1'b1 && !tx_dead) begin
            ph = 1;
        end else if (ph == 1) begin
            ph = 2;
        end else if (ph == 2) begin
            ph     = 0;
            txBusy = 1'b1;
            rem    = TX_LEN;
        end else if (txBusy) begin
            rem = rem - 1;
            if (rem == 0) begin
                txBusy   = 1'b0;
                fall_cyc = cyc;
            end
        end
    end

    task automatic wait_writes(input int n, input int budget, input string name);
        int t = 0;
        while (wr_q.size() < n && t < budget) begin
            @(negedge clk);
            t++;
        end
        chk({name, "_write_count_reached"}, 32'(wr_q.size() >= n), 32'd1);
    endtask

    task automatic wait_at_target(input int budget, input string name);
        int t = 0;
        while (at_target !== 1'b1 && t < budget) begin
            @(negedge clk);
            t++;
        end
        chk({name, "_at_target"}, 32'(at_target), 32'd1);
    endtask

    task automatic apply(input int tgt, input int g);
        @(negedge clk);
        target    = 12'(tgt);
        iGain     = g[0];
        target_we = 1'b1;
        @(negedge clk);
        target_we = 1'b0;
    endtask

    initial begin
        int we_cyc;
        int p_cyc;
        int rev_exp[$];
        int trig_n;
        int tmo_code;

`ifdef DAC_RAMP_SLEW_EN
        vecs[0] = '{100, 0, 7, '{16, 32, 48, 64, 80, 96, 100, 0}};
        vecs[1] = '{60,  0, 3, '{84, 68, 60, 0, 0, 0, 0, 0}};
        vecs[2] = '{60,  1, 1, '{60, 0, 0, 0, 0, 0, 0, 0}};
        vecs[3] = '{120, 1, 4, '{76, 92, 108, 120, 0, 0, 0, 0}};
        vecs[4] = '{0,   0, 8, '{104, 88, 72, 56, 40, 24, 8, 0}};
        rev_exp  = '{16, 32, 48, 64, 48, 32, 16, 0};
        trig_n   = 4;
        tmo_code = 16;
`else
        vecs[0] = '{100, 0, 1, '{100, 0, 0, 0, 0, 0, 0, 0}};
        vecs[1] = '{60,  0, 1, '{60, 0, 0, 0, 0, 0, 0, 0}};
        vecs[2] = '{60,  1, 1, '{60, 0, 0, 0, 0, 0, 0, 0}};
        vecs[3] = '{120, 1, 1, '{120, 0, 0, 0, 0, 0, 0, 0}};
        vecs[4] = '{0,   0, 1, '{0, 0, 0, 0, 0, 0, 0, 0}};
        rev_exp  = '{4095, 0};
        trig_n   = 1;
        tmo_code = 200;
`endif

        target    = 12'd0;
        target_we = 1'b0;
        iGain     = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_odata", 32'(odata), 32'd0);
        chk("rst_oGain", 32'(oGain), 32'd0);
        chk("rst_newTxData", 32'(newTxData), 32'd0);
        chk("rst_at_target", 32'(at_target), 32'd0);
        chk("rst_err_tmo", 32'(err_tmo), 32'd0);
        reset = 1'b0;

        wait_writes(1, 100, "sync");
        chk("sync_code", 32'(wr_q.size() > 0 ? wr_q[0].code : -1), 32'd0);
        chk("sync_gain", 32'(wr_q.size() > 0 ? wr_q[0].gain : -1), 32'd0);
        wait_at_target(200, "sync");
        chk("sync_count", 32'(wr_q.size()), 32'd1);

        for (int i = 0; i < 5; i++) begin
            wr_q.delete();
            @(negedge clk);
            we_cyc = cyc;
            target    = 12'(vecs[i].tgt);
            iGain     = vecs[i].g[0];
            target_we = 1'b1;
            @(negedge clk);
            target_we = 1'b0;
            wait_writes(vecs[i].n, 800, $sformatf("vec%0d", i));
            wait_at_target(800, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d_count", i), 32'(wr_q.size()), 32'(vecs[i].n));
            chk($sformatf("vec%0d_latency", i), 32'(wr_q.size() > 0 ? wr_q[0].cyc - we_cyc : -1), 32'd2);
            for (int j = 0; j < vecs[i].n; j++) begin
                chk($sformatf("vec%0d_code%0d", i, j), 32'(j < wr_q.size() ? wr_q[j].code : -1), 32'(vecs[i].codes[j]));
                chk($sformatf("vec%0d_gain%0d", i, j), 32'(j < wr_q.size() ? wr_q[j].gain : -1), 32'(vecs[i].g));
            end
        end

        // ramp reversal: new target arrives after a write is already in flight
        wr_q.delete();
        apply(4095, 0);
        wait_writes(trig_n, 1000, "rev_trig");
        apply(0, 0);
        wait_writes(rev_exp.size(), 1000, "rev");
        wait_at_target(1000, "rev");
        chk("rev_count", 32'(wr_q.size()), 32'(rev_exp.size()));
        for (int j = 0; j < rev_exp.size(); j++)
            chk($sformatf("rev_code%0d", j), 32'(j < wr_q.size() ? wr_q[j].code : -1), 32'(rev_exp[j]));

        // transmitter never answers: sticky timeout, same step retried
        wr_q.delete();
        tx_dead = 1'b1;
        apply(200, 0);
        wait_writes(1, 100, "tmo_first");
        p_cyc = (wr_q.size() > 0) ? wr_q[0].cyc : cyc;
        while (cyc < p_cyc + BUSY_TMO - 1) @(negedge clk);
        chk("tmo_not_yet", 32'(err_tmo), 32'd0);
        @(negedge clk);
        chk("tmo_set", 32'(err_tmo), 32'd1);
        wait_writes(2, 100, "tmo_retry");
        chk("tmo_code0", 32'(wr_q.size() > 0 ? wr_q[0].code : -1), 32'(tmo_code));
        chk("tmo_retry_code", 32'(wr_q.size() > 1 ? wr_q[1].code : -1), 32'(tmo_code));
        tx_dead = 1'b0;
        wait_at_target(2000, "tmo");
        chk("tmo_final_code", 32'(wr_q.size() > 0 ? wr_q[wr_q.size()-1].code : -1), 32'd200);
        chk("tmo_sticky", 32'(err_tmo), 32'd1);

        // asynchronous reset while a transfer is in WAIT_DONE
        wr_q.delete();
        apply(500, 1);
        wait_writes(1, 100, "rst_mid");
        for (int t = 0; t < 20 && txBusy !== 1'b1; t++) @(negedge clk);
        chk("rst_mid_busy", 32'(txBusy), 32'd1);
        repeat (3) @(negedge clk);
        chk("rst_mid_oGain_before", 32'(oGain), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("arst_odata", 32'(odata), 32'd0);
        chk("arst_oGain", 32'(oGain), 32'd0);
        chk("arst_newTxData", 32'(newTxData), 32'd0);
        chk("arst_at_target", 32'(at_target), 32'd0);
        chk("arst_err_tmo", 32'(err_tmo), 32'd0);
        @(negedge clk);
        @(negedge clk);
        wr_q.delete();
        reset = 1'b0;
        wait_writes(1, 100, "resync");
        chk("resync_code", 32'(wr_q.size() > 0 ? wr_q[0].code : -1), 32'd0);
        chk("resync_gain", 32'(wr_q.size() > 0 ? wr_q[0].gain : -1), 32'd0);
        wait_at_target(200, "resync");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
